// File: rtl/vga_framebuffer_scanout.sv
// VGA read-side scanout: raster counters, framebuffer address generation and a
// 3-stage pipeline (address, RAM read, pin registers) driving RGB/sync/blank to the DAC.
module vga_framebuffer_scanout #(
    parameter int unsigned H_ACTIVE   = 640,
    parameter int unsigned H_FP       = 16,
    parameter int unsigned H_SYNC     = 96,
    parameter int unsigned H_BP       = 48,
    parameter int unsigned V_ACTIVE   = 480,
    parameter int unsigned V_FP       = 10,
    parameter int unsigned V_SYNC     = 2,
    parameter int unsigned V_BP       = 33,
    parameter int unsigned IMG_W      = 256,
    parameter int unsigned IMG_H      = 256,
    parameter int unsigned IMG_X0     = 192,
    parameter int unsigned IMG_Y0     = 112,
    parameter int unsigned SCALE_LOG2 = 0,
    parameter logic [23:0] BG_COLOR   = 24'h000000
) (
    input  logic        clock_i,
    input  logic        reset_i,
    output logic [31:0] rd_addr_o,
    input  logic [7:0]  rd_data_i,
    output logic [7:0]  vga_r_o,
    output logic [7:0]  vga_g_o,
    output logic [7:0]  vga_b_o,
    output logic        vga_hsync_n_o,
    output logic        vga_vsync_n_o,
    output logic        vga_blank_n_o,
    output logic        vga_sync_n_o,
    output logic        frame_start_o
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HW      = $clog2(H_TOTAL);
    localparam int unsigned VW      = $clog2(V_TOTAL);
    localparam int unsigned WIN_W   = IMG_W << SCALE_LOG2;
    localparam int unsigned WIN_H   = IMG_H << SCALE_LOG2;

    localparam int CTL_ACT = 0;
    localparam int CTL_HS  = 1;
    localparam int CTL_VS  = 2;
    localparam int CTL_WIN = 3;
    localparam int CTL_FS  = 4;

    logic [HW-1:0] h_q, h_d;
    logic [VW-1:0] v_q, v_d;
    logic [31:0]   h_ext, v_ext, x_off, y_off, addr_d, rd_addr_q;
    logic [4:0]    ctl_d, ctl1_q, ctl2_q;
    logic [23:0]   rgb_d, rgb_q;
    logic          hsync_n_q, vsync_n_q, blank_n_q, frame_start_q;

    always_comb begin
        h_d = h_q + HW'(1);
        v_d = v_q;
        if (h_q == HW'(H_TOTAL - 1)) begin
            h_d = '0;
            v_d = (v_q == VW'(V_TOTAL - 1)) ? '0 : v_q + VW'(1);
        end
    end

    // Offsets wrap to huge values left/above an origin, so one unsigned compare bounds each range.
    always_comb begin
        h_ext  = 32'(h_q);
        v_ext  = 32'(v_q);
        x_off  = h_ext - IMG_X0;
        y_off  = v_ext - IMG_Y0;
        ctl_d  = '0;
        ctl_d[CTL_ACT] = (h_ext < H_ACTIVE) && (v_ext < V_ACTIVE);
        ctl_d[CTL_HS]  = (h_ext - (H_ACTIVE + H_FP)) < H_SYNC;
        ctl_d[CTL_VS]  = (v_ext - (V_ACTIVE + V_FP)) < V_SYNC;
        ctl_d[CTL_WIN] = (x_off < WIN_W) && (y_off < WIN_H);
        ctl_d[CTL_FS]  = (h_q == '0) && (v_ext == V_ACTIVE);
        addr_d = 32'd0;
        if (ctl_d[CTL_WIN]) begin
            addr_d = (y_off >> SCALE_LOG2) * IMG_W + (x_off >> SCALE_LOG2);
        end
    end

    always_comb begin
        rgb_d = 24'h000000;
        if (ctl2_q[CTL_ACT]) begin
            if (ctl2_q[CTL_WIN]) begin
                rgb_d = {rd_data_i[7:5], rd_data_i[7:5], rd_data_i[7:6],
                         rd_data_i[4:2], rd_data_i[4:2], rd_data_i[4:3],
                         rd_data_i[1:0], rd_data_i[1:0], rd_data_i[1:0], rd_data_i[1:0]};
            end else begin
                rgb_d = BG_COLOR;
            end
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            h_q           <= '0;
            v_q           <= '0;
            rd_addr_q     <= '0;
            ctl1_q        <= '0;
            ctl2_q        <= '0;
            rgb_q         <= '0;
            hsync_n_q     <= 1'b1;
            vsync_n_q     <= 1'b1;
            blank_n_q     <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            h_q           <= h_d;
            v_q           <= v_d;
            rd_addr_q     <= addr_d;
            ctl1_q        <= ctl_d;
            ctl2_q        <= ctl1_q;
            rgb_q         <= rgb_d;
            hsync_n_q     <= ~ctl2_q[CTL_HS];
            vsync_n_q     <= ~ctl2_q[CTL_VS];
            blank_n_q     <= ctl2_q[CTL_ACT];
            frame_start_q <= ctl2_q[CTL_FS];
        end
    end

    assign rd_addr_o     = rd_addr_q;
    assign vga_r_o       = rgb_q[23:16];
    assign vga_g_o       = rgb_q[15:8];
    assign vga_b_o       = rgb_q[7:0];
    assign vga_hsync_n_o = hsync_n_q;
    assign vga_vsync_n_o = vsync_n_q;
    assign vga_blank_n_o = blank_n_q;
    assign vga_sync_n_o  = 1'b0;
    assign frame_start_o = frame_start_q;

endmodule

// File: tb/tb_vga_framebuffer_scanout.sv
// Bench for vga_framebuffer_scanout: three configurations checked against a raster model,
// a table of spot pixels, per-frame timing totals and mid-frame resets.
module tb_vga_framebuffer_scanout;

    typedef struct {
        int ha, hf, hs, hb, va, vf, vs, vb, iw, ih, ix, iy, sc;
        logic [23:0] bg;
    } cfg_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [7:0]  r, g, b;
        logic        hs, vs, bl, sn, fs;
    } obs_t;

    typedef struct {
        int          k, h, v;
        logic [31:0] addr;
        logic [23:0] rgb;
        logic        bl;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [31:0] addr_w [3];
    logic [7:0]  rdd [3];
    logic [7:0]  r_w [3];
    logic [7:0]  g_w [3];
    logic [7:0]  b_w [3];
    logic        hs_w [3];
    logic        vs_w [3];
    logic        bl_w [3];
    logic        sn_w [3];
    logic        fs_w [3];
    logic [7:0]  mem [0:65535];

    int   cyc = 0;
    bit   started = 1'b0;
    bit   tbl_on = 1'b0;
    int   total = 0;
    int   bad = 0;
    vec_t tab[$];
    int   hit_a [64];
    int   hit_p [64];
    bit   have_pulse = 1'b0;
    int   per = 0, hs_lo = 0, vs_lo = 0, bl_hi = 0, frames_ok = 0;

    vga_framebuffer_scanout #(.IMG_Y0(2), .BG_COLOR(24'h204060)) dut_f (
        .clock_i(clk), .reset_i(rst), .rd_addr_o(addr_w[0]), .rd_data_i(rdd[0]),
        .vga_r_o(r_w[0]), .vga_g_o(g_w[0]), .vga_b_o(b_w[0]),
        .vga_hsync_n_o(hs_w[0]), .vga_vsync_n_o(vs_w[0]), .vga_blank_n_o(bl_w[0]),
        .vga_sync_n_o(sn_w[0]), .frame_start_o(fs_w[0]));

    vga_framebuffer_scanout #(
        .H_ACTIVE(40), .H_FP(4), .H_SYNC(8), .H_BP(6),
        .V_ACTIVE(30), .V_FP(2), .V_SYNC(2), .V_BP(3),
        .IMG_W(16), .IMG_H(16), .IMG_X0(12), .IMG_Y0(7), .BG_COLOR(24'h0A0B0C)) dut_s (
        .clock_i(clk), .reset_i(rst), .rd_addr_o(addr_w[1]), .rd_data_i(rdd[1]),
        .vga_r_o(r_w[1]), .vga_g_o(g_w[1]), .vga_b_o(b_w[1]),
        .vga_hsync_n_o(hs_w[1]), .vga_vsync_n_o(vs_w[1]), .vga_blank_n_o(bl_w[1]),
        .vga_sync_n_o(sn_w[1]), .frame_start_o(fs_w[1]));

    vga_framebuffer_scanout #(.SCALE_LOG2(1), .IMG_X0(64), .IMG_Y0(0)) dut_z (
        .clock_i(clk), .reset_i(rst), .rd_addr_o(addr_w[2]), .rd_data_i(rdd[2]),
        .vga_r_o(r_w[2]), .vga_g_o(g_w[2]), .vga_b_o(b_w[2]),
        .vga_hsync_n_o(hs_w[2]), .vga_vsync_n_o(vs_w[2]), .vga_blank_n_o(bl_w[2]),
        .vga_sync_n_o(sn_w[2]), .frame_start_o(fs_w[2]));

    // cyc counts clock edges since reset was last sampled high
    always @(posedge clk) begin
        if (rst) begin
            cyc     <= 0;
            started <= 1'b1;
        end else begin
            cyc <= cyc + 1;
        end
    end

    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) rdd[k] <= mem[addr_w[k][15:0]];
    end

    function automatic cfg_t get_cfg(int k);
        cfg_t cf;
        case (k)
            0:       cf = '{640, 16, 96, 48, 480, 10, 2, 33, 256, 256, 192, 2, 0, 24'h204060};
            1:       cf = '{40, 4, 8, 6, 30, 2, 2, 3, 16, 16, 12, 7, 0, 24'h0A0B0C};
            default: cf = '{640, 16, 96, 48, 480, 10, 2, 33, 256, 256, 64, 0, 1, 24'h000000};
        endcase
        return cf;
    endfunction

    function automatic int win_addr(cfg_t cf, int h, int v);
        if (h >= cf.ix && h < cf.ix + (cf.iw << cf.sc) && v >= cf.iy && v < cf.iy + (cf.ih << cf.sc))
            return ((v - cf.iy) >> cf.sc) * cf.iw + ((h - cf.ix) >> cf.sc);
        return -1;
    endfunction

    // n-bit channel scaled to 0..255 with rounding
    function automatic logic [23:0] expand(logic [7:0] p);
        int r3, g3, b2;
        r3 = int'(p[7:5]);
        g3 = int'(p[4:2]);
        b2 = int'(p[1:0]);
        return {8'((r3 * 510 + 7) / 14), 8'((g3 * 510 + 7) / 14), 8'(b2 * 85)};
    endfunction

    function automatic obs_t model(int k, int c);
        cfg_t cf;
        obs_t e;
        int ht, fr, idx, h, v, a;
        cf = get_cfg(k);
        ht = cf.ha + cf.hf + cf.hs + cf.hb;
        fr = ht * (cf.va + cf.vf + cf.vs + cf.vb);
        e = '0;
        e.hs = 1'b1;
        e.vs = 1'b1;
        if (c >= 1) begin
            idx = (c - 1) % fr;
            a = win_addr(cf, idx % ht, idx / ht);
            e.addr = (a >= 0) ? 32'(a) : 32'd0;
        end
        if (c >= 3) begin
            idx = (c - 3) % fr;
            h = idx % ht;
            v = idx / ht;
            e.hs = !(h >= cf.ha + cf.hf && h < cf.ha + cf.hf + cf.hs);
            e.vs = !(v >= cf.va + cf.vf && v < cf.va + cf.vf + cf.vs);
            e.bl = (h < cf.ha) && (v < cf.va);
            e.fs = (h == 0) && (v == cf.va);
            if (e.bl) begin
                a = win_addr(cf, h, v);
                if (a >= 0) {e.r, e.g, e.b} = expand(mem[a]);
                else        {e.r, e.g, e.b} = cf.bg;
            end
        end
        return e;
    endfunction

    function automatic void cmp(string nm, logic [63:0] got, logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", nm, got, want);
        end
    endfunction

    task automatic check_cycle();
        obs_t o;
        cfg_t cf;
        int pix;
        for (int k = 0; k < 3; k++) begin
            o.addr = addr_w[k]; o.r = r_w[k]; o.g = g_w[k]; o.b = b_w[k];
            o.hs = hs_w[k]; o.vs = vs_w[k]; o.bl = bl_w[k]; o.sn = sn_w[k]; o.fs = fs_w[k];
            cmp($sformatf("stream k%0d cyc%0d", k, cyc), 64'(o), 64'(model(k, cyc)));
        end
        if (tbl_on) begin
            for (int i = 0; i < tab.size(); i++) begin
                cf  = get_cfg(tab[i].k);
                pix = tab[i].v * (cf.ha + cf.hf + cf.hs + cf.hb) + tab[i].h;
                if (cyc - 1 == pix) begin
                    cmp($sformatf("addr k%0d (%0d,%0d)", tab[i].k, tab[i].h, tab[i].v),
                        64'(addr_w[tab[i].k]), 64'(tab[i].addr));
                    hit_a[i]++;
                end
                if (cyc - 3 == pix) begin
                    cmp($sformatf("rgb k%0d (%0d,%0d)", tab[i].k, tab[i].h, tab[i].v),
                        64'({r_w[tab[i].k], g_w[tab[i].k], b_w[tab[i].k]}), 64'(tab[i].rgb));
                    cmp($sformatf("blank_n k%0d (%0d,%0d)", tab[i].k, tab[i].h, tab[i].v),
                        64'(bl_w[tab[i].k]), 64'(tab[i].bl));
                    hit_p[i]++;
                end
            end
        end
        if (cyc < 3) begin
            have_pulse = 1'b0;
        end else begin
            if (fs_w[1]) begin
                if (have_pulse) begin
                    cmp("frame_period", 64'(per), 64'(58 * 37));
                    cmp("hsync_low_per_frame", 64'(hs_lo), 64'(8 * 37));
                    cmp("vsync_low_per_frame", 64'(vs_lo), 64'(2 * 58));
                    cmp("blank_high_per_frame", 64'(bl_hi), 64'(40 * 30));
                    frames_ok++;
                end
                have_pulse = 1'b1;
                per = 0; hs_lo = 0; vs_lo = 0; bl_hi = 0;
            end
            per++;
            if (!hs_w[1]) hs_lo++;
            if (!vs_w[1]) vs_lo++;
            if (bl_w[1])  bl_hi++;
        end
    endtask

    task automatic step(int n);
        repeat (n) begin
            @(negedge clk);
            check_cycle();
        end
    endtask

    task automatic reset_pins_check(string tag);
        for (int k = 0; k < 3; k++) begin
            cmp($sformatf("%s hsync_n k%0d", tag, k), 64'(hs_w[k]), 64'd1);
            cmp($sformatf("%s vsync_n k%0d", tag, k), 64'(vs_w[k]), 64'd1);
            cmp($sformatf("%s blank_n k%0d", tag, k), 64'(bl_w[k]), 64'd0);
            cmp($sformatf("%s rd_addr k%0d", tag, k), 64'(addr_w[k]), 64'd0);
        end
    endtask

    task automatic scramble_mem();
        for (int a = 0; a < 65536; a++) mem[a] = 8'($urandom);
    endtask

    initial begin
        int guard;
        for (int a = 0; a < 65536; a++) mem[a] = 8'(a);
        for (int i = 0; i < 64; i++) begin hit_a[i] = 0; hit_p[i] = 0; end
        tab.push_back('{0, 0,   0, 32'd0,   24'h204060, 1'b1});
        tab.push_back('{0, 192, 2, 32'd0,   24'h000000, 1'b1});
        tab.push_back('{0, 193, 2, 32'd1,   24'h000055, 1'b1});
        tab.push_back('{0, 195, 2, 32'd3,   24'h0000FF, 1'b1});
        tab.push_back('{0, 220, 2, 32'd28,  24'h00FF00, 1'b1});
        tab.push_back('{0, 224, 2, 32'd32,  24'h240000, 1'b1});
        tab.push_back('{0, 416, 2, 32'd224, 24'hFF0000, 1'b1});
        tab.push_back('{0, 447, 2, 32'd255, 24'hFFFFFF, 1'b1});
        tab.push_back('{0, 448, 2, 32'd0,   24'h204060, 1'b1});
        tab.push_back('{0, 191, 2, 32'd0,   24'h204060, 1'b1});
        tab.push_back('{0, 192, 3, 32'd256, 24'h000000, 1'b1});
        tab.push_back('{0, 639, 3, 32'd0,   24'h204060, 1'b1});
        tab.push_back('{0, 640, 3, 32'd0,   24'h000000, 1'b0});
        tab.push_back('{2, 63,  0, 32'd0,   24'h000000, 1'b1});
        tab.push_back('{2, 64,  0, 32'd0,   24'h000000, 1'b1});
        tab.push_back('{2, 65,  1, 32'd0,   24'h000000, 1'b1});
        tab.push_back('{2, 66,  2, 32'd257, 24'h000055, 1'b1});
        tab.push_back('{2, 67,  3, 32'd257, 24'h000055, 1'b1});
        tab.push_back('{2, 68,  2, 32'd258, 24'h0000AA, 1'b1});
        tab.push_back('{1, 12,  7, 32'd0,   24'h000000, 1'b1});
        tab.push_back('{1, 15,  7, 32'd3,   24'h0000FF, 1'b1});
        tab.push_back('{1, 27,  7, 32'd15,  24'h006DFF, 1'b1});
        tab.push_back('{1, 12,  8, 32'd16,  24'h009200, 1'b1});
        tab.push_back('{1, 27, 22, 32'd255, 24'hFFFFFF, 1'b1});
        tab.push_back('{1, 11,  7, 32'd0,   24'h0A0B0C, 1'b1});
        tab.push_back('{1, 28,  7, 32'd0,   24'h0A0B0C, 1'b1});
        tab.push_back('{1, 40,  0, 32'd0,   24'h000000, 1'b0});

        step(5);
        reset_pins_check("por");
        rst = 1'b0;
        tbl_on = 1'b1;
        step(7000);
        tbl_on = 1'b0;

        // reset while dut_s's raster sits at (30,20)
        guard = 0;
        while ((cyc % 2146) != 1190 && guard < 3000) begin
            step(1);
            guard++;
        end
        cmp("reach_mid_frame", 64'(guard < 3000), 64'd1);
        rst = 1'b1;
        scramble_mem();
        step(1);
        reset_pins_check("midrst");
        rst = 1'b0;
        step(6600);

        step(int'($urandom_range(1, 2000)));
        rst = 1'b1;
        scramble_mem();
        step(int'($urandom_range(1, 4)));
        reset_pins_check("rndrst");
        rst = 1'b0;
        step(6600);

        for (int i = 0; i < tab.size(); i++) begin
            cmp($sformatf("tab%0d addr_seen", i), 64'(hit_a[i]), 64'd1);
            cmp($sformatf("tab%0d pix_seen", i), 64'(hit_p[i]), 64'd1);
        end
        cmp("frames_checked", 64'(frames_ok >= 6), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
